alu_cmd_seq: RTL and testbench

//  Command sequencer directly upstream of the 4-bit combinational ALU (ADD/SUB/MUL/XOR, alu_pkg::opcode_e).

---
 rtl/alu_cmd_seq_if.sv | 41 ++++
 rtl/alu_cmd_seq.sv | 149 ++++++++++++++
 tb/tb_alu_cmd_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_seq_if.sv
// Bus bundle between alu_cmd_seq and its environment: command input, ALU operand/result path, result output.
// res_zero is present only when ALU_CMD_SEQ_ZERO_FLAG_EN is defined.
interface alu_cmd_seq_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic [1:0]       cmd_op;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [1:0]       alu_op;
   logic [3:0]       alu_y;
   logic             res_valid;
   logic             res_ready;
   logic [3:0]       res_y;
   logic [1:0]       res_op;
   logic [CNT_W-1:0] op_count;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
   logic             res_zero;
`endif

   // Sequencer side
   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_y, res_ready,
      output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_y, res_op, op_count
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
      , output res_zero
`endif
   );

   // Environment side (command source, ALU, result consumer)
   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_y, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_y, res_op, op_count
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
      , input res_zero
`endif
   );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command FIFO + IDLE/EXEC/WAIT sequencer feeding a combinational 4-bit ALU and returning results on valid/ready.
// Optional zero flag on the result port: define ALU_CMD_SEQ_ZERO_FLAG_EN.
module alu_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   alu_cmd_seq_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_e;

   state_e           state_q, state_d;
   logic [9:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic [3:0]       res_y_q, res_y_d;
   logic [1:0]       res_op_q, res_op_d;
   logic             res_valid_q, res_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
   logic             res_zero_q, res_zero_d;
`endif

   logic       full, empty, push, pop;
   logic [9:0] head;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   // Push is gated by the registered full flag only, so a simultaneous pop never frees a slot early.
   assign push  = bus.cmd_valid && !full;
   assign head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         res_y_q     <= '0;
         res_op_q    <= '0;
         res_valid_q <= 1'b0;
         cnt_q       <= '0;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
         res_zero_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         res_y_q     <= res_y_d;
         res_op_q    <= res_op_d;
         res_valid_q <= res_valid_d;
         cnt_q       <= cnt_d;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
         res_zero_q  <= res_zero_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_y_d     = res_y_q;
      res_op_d    = res_op_q;
      res_valid_d = res_valid_q;
      cnt_d       = cnt_q;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
      res_zero_d  = res_zero_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            res_y_d     = bus.alu_y;
            res_op_d    = alu_op_q;
            res_valid_d = 1'b1;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
            res_zero_d  = (bus.alu_y == 4'h0);
`endif
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            // res_valid_q is always 1 here, so res_ready alone completes the handshake.
            if (bus.res_ready) begin
               cnt_d       = cnt_q + CNT_W'(1);
               res_valid_d = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         alu_a_d  = head[9:6];
         alu_b_d  = head[5:2];
         alu_op_d = head[1:0];
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_y     = res_y_q;
   assign bus.res_op    = res_op_q;
   assign bus.op_count  = cnt_q;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
   assign bus.res_zero  = res_zero_q;
`endif
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq: an 8-bit-counter instance and a 2-bit-counter instance share one stimulus stream.
// Zero-flag checks are compiled in when ALU_CMD_SEQ_ZERO_FLAG_EN is defined.
module tb_alu_cmd_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_cmd_seq_if #(.CNT_W(8)) if8();
   alu_cmd_seq_if #(.CNT_W(2)) if2();

   alu_cmd_seq #(.DEPTH(4), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   alu_cmd_seq #(.DEPTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      logic [7:0] p;
      p = {4'h0, a} * {4'h0, b};
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return p[3:0];
         default: return a ^ b;
      endcase
   endfunction

   assign if8.alu_y     = alu_f(if8.alu_a, if8.alu_b, if8.alu_op);
   assign if2.alu_y     = alu_f(if2.alu_a, if2.alu_b, if2.alu_op);
   assign if2.cmd_valid = if8.cmd_valid;
   assign if2.cmd_a     = if8.cmd_a;
   assign if2.cmd_b     = if8.cmd_b;
   assign if2.cmd_op    = if8.cmd_op;
   assign if2.res_ready = if8.res_ready;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int n = 0;
      if8.cmd_a     = a;
      if8.cmd_b     = b;
      if8.cmd_op    = op;
      if8.cmd_valid = 1'b1;
      while (!if8.cmd_ready && n < 20) begin
         step();
         n++;
      end
      if (n == 20) chk("send_timeout", 32'(if8.cmd_ready), 1);
      step();
      if8.cmd_valid = 1'b0;
   endtask

   // Waits for res_valid, checks the held result, then spends one edge for the handshake.
   task automatic wait_res(input string tag, input logic [3:0] y, input logic [1:0] op);
      int n = 0;
      while (!if8.res_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 32'(if8.res_valid), 1);
      chk({tag, "_y"}, 32'(if8.res_y), 32'(y));
      chk({tag, "_op"}, 32'(if8.res_op), 32'(op));
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
      chk({tag, "_zero"}, 32'(if8.res_zero), (y == 4'h0) ? 1 : 0);
`endif
      step();
   endtask

   initial begin
      rst_n         = 1'b0;
      if8.cmd_valid = 1'b0;
      if8.cmd_a     = '0;
      if8.cmd_b     = '0;
      if8.cmd_op    = '0;
      if8.res_ready = 1'b0;
      step();
      step();
      chk("rst_cmd_ready", 32'(if8.cmd_ready), 1);
      chk("rst_res_valid", 32'(if8.res_valid), 0);
      chk("rst_res_y", 32'(if8.res_y), 0);
      chk("rst_alu_a", 32'(if8.alu_a), 0);
      chk("rst_op_count", 32'(if8.op_count), 0);
      rst_n = 1'b1;

      // Single ADD: 2-cycle latency, op_count 0 -> 1.
      if8.res_ready = 1'b1;
      send(4'd3, 4'd4, 2'd0);
      step();
      chk("add_alu_a", 32'(if8.alu_a), 3);
      chk("add_alu_b", 32'(if8.alu_b), 4);
      chk("add_early_valid", 32'(if8.res_valid), 0);
      step();
      chk("add_valid", 32'(if8.res_valid), 1);
      chk("add_y", 32'(if8.res_y), 7);
      chk("add_op", 32'(if8.res_op), 0);
      chk("add_cnt_before", 32'(if8.op_count), 0);
      step();
      chk("add_cnt_after", 32'(if8.op_count), 1);
      chk("add_valid_drop", 32'(if8.res_valid), 0);
      chk("cnt2_seq0", 32'(if2.op_count), 1);

      // SUB wrap, MUL truncation, XOR zero
      send(4'd2, 4'd5, 2'd1);
      send(4'd7, 4'd3, 2'd2);
      wait_res("sub", 4'hD, 2'd1);
      chk("cnt2_seq1", 32'(if2.op_count), 2);
      wait_res("mul", 4'h5, 2'd2);
      chk("cnt2_seq2", 32'(if2.op_count), 3);
      send(4'd9, 4'd9, 2'd3);
      wait_res("xor", 4'h0, 2'd3);
      chk("cnt2_seq3", 32'(if2.op_count), 0);
      chk("cnt8_4", 32'(if8.op_count), 4);

      // Fill: one in EXEC/WAIT plus four queued while the consumer stalls.
      if8.res_ready = 1'b0;
      send(4'd1, 4'd1, 2'd0);
      send(4'd5, 4'd3, 2'd1);
      send(4'd3, 4'd3, 2'd2);
      send(4'd6, 4'd5, 2'd3);
      send(4'd15, 4'd1, 2'd0);
      chk("full_cmd_ready", 32'(if8.cmd_ready), 0);
      chk("full_res_valid", 32'(if8.res_valid), 1);
      chk("full_res_y", 32'(if8.res_y), 2);
      if8.cmd_a     = 4'd2;
      if8.cmd_b     = 4'd2;
      if8.cmd_op    = 2'd0;
      if8.cmd_valid = 1'b1;
      step();
      step();
      chk("stall_cmd_ready", 32'(if8.cmd_ready), 0);
      chk("stall_res_y", 32'(if8.res_y), 2);
      chk("stall_alu_a", 32'(if8.alu_a), 1);
      // Pop from a full FIFO while cmd_valid is high: no push this edge.
      if8.res_ready = 1'b1;
      step();
      chk("popfull_cmd_ready", 32'(if8.cmd_ready), 1);
      chk("popfull_res_valid", 32'(if8.res_valid), 0);
      chk("popfull_alu_a", 32'(if8.alu_a), 5);
      chk("cnt2_seq4", 32'(if2.op_count), 1);
      step();
      chk("blocked_accepted", 32'(if8.cmd_ready), 0);
      if8.cmd_valid = 1'b0;
      wait_res("f1", 4'h2, 2'd1);
      wait_res("f2", 4'h9, 2'd2);
      wait_res("f3", 4'h3, 2'd3);
      wait_res("f4", 4'h0, 2'd0);
      wait_res("f5", 4'h4, 2'd0);
      chk("cnt8_10", 32'(if8.op_count), 10);
      chk("cnt2_10", 32'(if2.op_count), 2);

      // Reset while WAIT holds a result and two commands are queued.
      if8.res_ready = 1'b0;
      send(4'd1, 4'd2, 2'd0);
      send(4'd2, 4'd2, 2'd0);
      send(4'd3, 4'd3, 2'd3);
      chk("pre_rst_valid", 32'(if8.res_valid), 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_valid", 32'(if8.res_valid), 0);
      chk("mid_rst_cmd_ready", 32'(if8.cmd_ready), 1);
      chk("mid_rst_res_y", 32'(if8.res_y), 0);
      chk("mid_rst_res_op", 32'(if8.res_op), 0);
      chk("mid_rst_alu", 32'({if8.alu_a, if8.alu_b, if8.alu_op}), 0);
      chk("mid_rst_cnt", 32'(if8.op_count), 0);
      if8.res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_quiet", 32'(if8.res_valid), 0);
      end
      send(4'd3, 4'd4, 2'd0);
      wait_res("post_rst_add", 4'h7, 2'd0);
      chk("post_rst_cnt", 32'(if8.op_count), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
